matris_is_zamanlayici: RTL and testbench

//   Job queue and dispatcher for the matrix multiplier. Accepts multiply jobs
//   (size, A addr, B addr, result addr) from the host/CPU side into a FIFO and

---
 rtl/matris_is_zamanlayici_if.sv | 36 +++
 rtl/matris_is_zamanlayici.sv | 159 +++++++++++++++
 tb/tb_matris_is_zamanlayici.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matris_is_zamanlayici_if.sv
// Host job channel and multiplier start handshake of the matrix job scheduler.
// master: host/multiplier side, slave: the scheduler itself.
interface matris_is_zamanlayici_if #(
    parameter int unsigned ADRES_BIT  = 32,
    parameter int unsigned KIMLIK_BIT = 4
);
    logic [ADRES_BIT-1:0]  is_boyut_g;
    logic [ADRES_BIT-1:0]  is_adres1_g;
    logic [ADRES_BIT-1:0]  is_adres2_g;
    logic [ADRES_BIT-1:0]  is_adres_sonuc_g;
    logic                  is_gecerli_g;
    logic                  is_hazir_c;
    logic [KIMLIK_BIT-1:0] is_kimlik_c;
    logic                  is_red_c;

    logic [ADRES_BIT-1:0]  at_boyut_c;
    logic [ADRES_BIT-1:0]  at_adres1_c;
    logic [ADRES_BIT-1:0]  at_adres2_c;
    logic [ADRES_BIT-1:0]  at_adres_sonuc_c;
    logic                  at_gecerli_c;
    logic                  at_mesgul_g;

    modport master (
        output is_boyut_g, is_adres1_g, is_adres2_g, is_adres_sonuc_g, is_gecerli_g,
        input  is_hazir_c, is_kimlik_c, is_red_c,
        input  at_boyut_c, at_adres1_c, at_adres2_c, at_adres_sonuc_c, at_gecerli_c,
        output at_mesgul_g
    );

    modport slave (
        input  is_boyut_g, is_adres1_g, is_adres2_g, is_adres_sonuc_g, is_gecerli_g,
        output is_hazir_c, is_kimlik_c, is_red_c,
        output at_boyut_c, at_adres1_c, at_adres2_c, at_adres_sonuc_c, at_gecerli_c,
        input  at_mesgul_g
    );
endinterface

// File: rtl/matris_is_zamanlayici.sv
// Matrix multiply job queue: buffers host jobs in a FIFO and dispatches them one
// at a time to the multiplier, reporting completion IDs and start timeouts.
module matris_is_zamanlayici #(
    parameter int unsigned ADRES_BIT  = 32,
    parameter int unsigned DERINLIK   = 4,
    parameter int unsigned KIMLIK_BIT = 4,
    parameter int unsigned MAKS_BOYUT = 4,
    parameter int unsigned BASLA_SURE = 8
) (
    input  logic                      clk_g,
    input  logic                      resetn,
    matris_is_zamanlayici_if.slave    bus,
    output logic                      bitti_c,
    output logic [KIMLIK_BIT-1:0]     bitti_kimlik_c,
    output logic                      zaman_asimi_c,
    output logic [$clog2(DERINLIK):0] doluluk_c
);
    localparam int unsigned PTR_W  = $clog2(DERINLIK);
    localparam int unsigned SAY_W  = PTR_W + 1;
    localparam int unsigned SURE_W = $clog2(BASLA_SURE + 1);

    typedef struct packed {
        logic [ADRES_BIT-1:0]  boyut;
        logic [ADRES_BIT-1:0]  adres1;
        logic [ADRES_BIT-1:0]  adres2;
        logic [ADRES_BIT-1:0]  adres_sonuc;
        logic [KIMLIK_BIT-1:0] kimlik;
    } is_t;

    typedef enum logic [3:0] {
        BOSTA       = 4'b0001,
        GONDER      = 4'b0010,
        BASLA_BEKLE = 4'b0100,
        CALISMA     = 4'b1000
    } durum_t;

    is_t                   mem_q [DERINLIK];
    logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [SAY_W-1:0]      say_q, say_d;
    logic [KIMLIK_BIT-1:0] kimlik_q, kimlik_d;
    logic [SURE_W-1:0]     sure_q, sure_d;
    logic                  red_q, red_d;
    logic                  zaman_q, zaman_d;
    durum_t                durum_q, durum_d;
    is_t                   at_q, at_d;

    logic dolu_c, bos_c, hazir_c, boyut_ok_c, kabul_c, push_c, pop_c;
    is_t  bas_c, yeni_c;

    // Accept logic, FIFO bookkeeping and dispatch FSM
    always_comb begin
        dolu_c     = (say_q == SAY_W'(DERINLIK));
        bos_c      = (say_q == '0);
        hazir_c    = resetn & ~dolu_c & ~zaman_q;
        boyut_ok_c = (bus.is_boyut_g != '0) && (bus.is_boyut_g <= ADRES_BIT'(MAKS_BOYUT));
        kabul_c    = bus.is_gecerli_g & hazir_c;
        push_c     = kabul_c & boyut_ok_c;
        bas_c      = mem_q[rd_q];

        yeni_c.boyut       = bus.is_boyut_g;
        yeni_c.adres1      = bus.is_adres1_g;
        yeni_c.adres2      = bus.is_adres2_g;
        yeni_c.adres_sonuc = bus.is_adres_sonuc_g;
        yeni_c.kimlik      = kimlik_q;

        durum_d = durum_q;
        sure_d  = sure_q;
        zaman_d = zaman_q;
        at_d    = at_q;
        pop_c   = 1'b0;
        bitti_c = 1'b0;

        case (durum_q)
            BOSTA: begin
                if (!bos_c && !bus.at_mesgul_g) begin
                    durum_d = GONDER;
                    at_d    = bas_c;
                end
            end
            GONDER: begin
                durum_d = BASLA_BEKLE;
                sure_d  = '0;
            end
            BASLA_BEKLE: begin
                // Once timed out the queue stays frozen until reset
                if (!zaman_q) begin
                    if (bus.at_mesgul_g) begin
                        durum_d = CALISMA;
                    end else if (sure_q == SURE_W'(BASLA_SURE - 1)) begin
                        zaman_d = 1'b1;
                    end else begin
                        sure_d = sure_q + SURE_W'(1);
                    end
                end
            end
            CALISMA: begin
                if (!bus.at_mesgul_g && resetn) begin
                    pop_c   = 1'b1;
                    bitti_c = 1'b1;
                    durum_d = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase

        wr_d = push_c ? wr_q + PTR_W'(1) : wr_q;
        rd_d = pop_c  ? rd_q + PTR_W'(1) : rd_q;
        case ({push_c, pop_c})
            2'b10:   say_d = say_q + SAY_W'(1);
            2'b01:   say_d = say_q - SAY_W'(1);
            default: say_d = say_q;
        endcase
        kimlik_d = push_c ? kimlik_q + KIMLIK_BIT'(1) : kimlik_q;
        red_d    = kabul_c & ~boyut_ok_c;
    end

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            wr_q     <= '0;
            rd_q     <= '0;
            say_q    <= '0;
            kimlik_q <= '0;
            sure_q   <= '0;
            red_q    <= 1'b0;
            zaman_q  <= 1'b0;
            durum_q  <= BOSTA;
            at_q     <= '0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            say_q    <= say_d;
            kimlik_q <= kimlik_d;
            sure_q   <= sure_d;
            red_q    <= red_d;
            zaman_q  <= zaman_d;
            durum_q  <= durum_d;
            at_q     <= at_d;
        end
    end

    // Job storage; contents need no reset since the pointers gate every read
    always_ff @(posedge clk_g) begin
        if (push_c) begin
            mem_q[wr_q] <= yeni_c;
        end
    end

    assign bus.is_hazir_c       = hazir_c;
    assign bus.is_kimlik_c      = kimlik_q;
    assign bus.is_red_c         = red_q;
    assign bus.at_boyut_c       = at_q.boyut;
    assign bus.at_adres1_c      = at_q.adres1;
    assign bus.at_adres2_c      = at_q.adres2;
    assign bus.at_adres_sonuc_c = at_q.adres_sonuc;
    assign bus.at_gecerli_c     = (durum_q == GONDER);
    assign bitti_kimlik_c       = bitti_c ? bas_c.kimlik : '0;
    assign zaman_asimi_c        = zaman_q;
    assign doluluk_c            = say_q;
endmodule

// File: tb/tb_matris_is_zamanlayici.sv
// Scoreboard bench for matris_is_zamanlayici: a queue model of accepted jobs
// predicts issue order, completion IDs, rejects and occupancy.
module tb_matris_is_zamanlayici;
    localparam int unsigned AB = 32, DER = 4, KB = 4, MAKS = 4, SURE = 8;

    logic clk_g  = 1'b0;
    logic resetn = 1'b0;
    always #5 clk_g = ~clk_g;

    matris_is_zamanlayici_if #(.ADRES_BIT(AB), .KIMLIK_BIT(KB)) bus ();
    logic                  bitti_c;
    logic [KB-1:0]         bitti_kimlik_c;
    logic                  zaman_asimi_c;
    logic [$clog2(DER):0]  doluluk_c;

    matris_is_zamanlayici #(
        .ADRES_BIT(AB), .DERINLIK(DER), .KIMLIK_BIT(KB), .MAKS_BOYUT(MAKS), .BASLA_SURE(SURE)
    ) dut (
        .clk_g(clk_g), .resetn(resetn), .bus(bus),
        .bitti_c(bitti_c), .bitti_kimlik_c(bitti_kimlik_c),
        .zaman_asimi_c(zaman_asimi_c), .doluluk_c(doluluk_c)
    );

    typedef struct { logic [31:0] b, a1, a2, ar; } job_t;
    job_t issue_q [$];
    int   compl_q [$];
    int   red_cyc_q [$];

    int checks = 0, failures = 0, cyc = 0, model_id = 0;
    int last_acc_cyc = 0, last_gec_cyc = 0, last_bitti_cyc = 0;
    int gec_cnt = 0, bitti_cnt = 0, red_cnt = 0, mul_len = 0;
    bit in_reset = 1'b1, exp_stuck = 1'b0, mul_respond = 1'b1, mul_abort = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic void fail_now(input string nm, input string why);
        checks++;
        failures++;
        $display("FAIL %s: %s", nm, why);
    endfunction

    always @(posedge clk_g) cyc <= cyc + 1;

    // Monitor: compares every DUT-presented event against the scoreboard queues
    always @(negedge clk_g) begin
        if (in_reset) begin
            if (bitti_c === 1'b1) fail_now("bitti_in_reset", "bitti_c=1 while resetn=0");
        end else begin
            chk("doluluk_c", doluluk_c, compl_q.size());
            if (bus.at_gecerli_c === 1'b1) begin
                last_gec_cyc = cyc;
                gec_cnt++;
                if (issue_q.size() == 0) fail_now("issue", "at_gecerli_c=1 with no job pending");
                else begin
                    chk("at_boyut_c", bus.at_boyut_c, issue_q[0].b);
                    chk("at_adres1_c", bus.at_adres1_c, issue_q[0].a1);
                    chk("at_adres2_c", bus.at_adres2_c, issue_q[0].a2);
                    chk("at_adres_sonuc_c", bus.at_adres_sonuc_c, issue_q[0].ar);
                    void'(issue_q.pop_front());
                end
            end
            if (bitti_c === 1'b1) begin
                last_bitti_cyc = cyc;
                bitti_cnt++;
                if (compl_q.size() == 0) fail_now("bitti", "bitti_c=1 with no job outstanding");
                else chk("bitti_kimlik_c", bitti_kimlik_c, compl_q.pop_front());
            end
            if (red_cyc_q.size() != 0 && red_cyc_q[0] == cyc) begin
                chk("is_red_c", bus.is_red_c, 1);
                red_cnt++;
                void'(red_cyc_q.pop_front());
            end else if (bus.is_red_c !== 1'b0) begin
                fail_now("is_red_c", "pulse without a rejected job");
            end
        end
    end

    // Multiplier model: busy rises 1..3 cycles after a start pulse
    initial begin
        int md, mn;
        bus.at_mesgul_g = 1'b0;
        forever begin
            @(negedge clk_g);
            if (bus.at_gecerli_c === 1'b1 && mul_respond) begin
                md = $urandom_range(1, 3);
                for (int k = 0; k < md && !mul_abort; k++) @(posedge clk_g);
                #1 bus.at_mesgul_g = 1'b1;
                mn = (mul_len != 0) ? mul_len : $urandom_range(1, 10);
                for (int k = 0; k < mn && !mul_abort; k++) @(posedge clk_g);
                #1 bus.at_mesgul_g = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_g);
        #2;
    endtask

    task automatic send(input logic [31:0] b, a1, a2, ar, input int max_wait, output bit ok);
        bit   h;
        job_t j;
        ok = 1'b0;
        bus.is_boyut_g = b; bus.is_adres1_g = a1; bus.is_adres2_g = a2; bus.is_adres_sonuc_g = ar;
        bus.is_gecerli_g = 1'b1;
        for (int w = 0; w <= max_wait && !ok; w++) begin
            h = !exp_stuck && (compl_q.size() < DER);
            chk("is_hazir_c", bus.is_hazir_c, h);
            if (h) begin
                chk("is_kimlik_c", bus.is_kimlik_c, model_id);
                ok = 1'b1;
                last_acc_cyc = cyc;
            end
            @(posedge clk_g);
            if (ok) begin
                if (b >= 1 && b <= MAKS) begin
                    j = '{b, a1, a2, ar};
                    issue_q.push_back(j);
                    compl_q.push_back(model_id);
                    model_id = (model_id + 1) % (1 << KB);
                end else begin
                    red_cyc_q.push_back(last_acc_cyc + 1);
                end
            end
            #2;
        end
        bus.is_gecerli_g = 1'b0;
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        resetn   = 1'b0;
        issue_q.delete(); compl_q.delete(); red_cyc_q.delete();
        model_id  = 0;
        exp_stuck = 1'b0;
        repeat (3) @(posedge clk_g);
        #2;
        chk("rst_is_hazir_c", bus.is_hazir_c, 0);
        chk("rst_doluluk_c", doluluk_c, 0);
        chk("rst_is_kimlik_c", bus.is_kimlik_c, 0);
        chk("rst_at_gecerli_c", bus.at_gecerli_c, 0);
        chk("rst_at_boyut_c", bus.at_boyut_c, 0);
        chk("rst_bitti_c", bitti_c, 0);
        chk("rst_zaman_asimi_c", zaman_asimi_c, 0);
        chk("rst_is_red_c", bus.is_red_c, 0);
        resetn   = 1'b1;
        in_reset = 1'b0;
        #1;
        chk("rel_is_hazir_c", bus.is_hazir_c, 1);
        tick();
    endtask

    task automatic drain(input int bound);
        for (int w = 0; w < bound && compl_q.size() != 0; w++) tick();
        if (compl_q.size() != 0) fail_now("drain", "jobs still outstanding after cycle budget");
    endtask

    task automatic wait_issue(input int g0);
        for (int w = 0; w < 60 && gec_cnt == g0; w++) tick();
        if (gec_cnt == g0) fail_now("wait_issue", "no at_gecerli_c within cycle budget");
    endtask

    initial begin
        bit ok;
        int g0, r0, b0;
        logic [31:0] rb;
        bus.is_gecerli_g = 1'b0;
        bus.is_boyut_g = '0; bus.is_adres1_g = '0; bus.is_adres2_g = '0; bus.is_adres_sonuc_g = '0;
        do_reset();

        // single job: 2-cycle latency, busy 20 cycles, ID 0
        mul_len = 20;
        g0 = gec_cnt;
        send(32'd2, 32'h1000, 32'h2000, 32'h3000, 5, ok);
        wait_issue(g0);
        chk("t1_latency", 64'(last_gec_cyc - last_acc_cyc), 2);
        drain(100);

        // fill the FIFO behind a long job, 5th push ignored, retry after completion
        do_reset();
        mul_len = 60;
        for (int i = 0; i < 4; i++) send(32'(i + 1), $urandom, $urandom, $urandom, 5, ok);
        chk("t2_doluluk_full", doluluk_c, 4);
        chk("t2_is_hazir_full", bus.is_hazir_c, 0);
        send(32'd3, 32'h55, 32'h66, 32'h77, 0, ok);
        send(32'd4, 32'hA0, 32'hB0, 32'hC0, 200, ok);
        chk("t4_accept_after_bitti", 64'(last_acc_cyc), 64'(last_bitti_cyc + 1));
        chk("t4_doluluk_refill", doluluk_c, 4);
        mul_len = 0;
        drain(800);

        // illegal sizes rejected without consuming an ID
        do_reset();
        r0 = red_cnt;
        send(32'd0, 32'h1, 32'h2, 32'h3, 5, ok);
        send(32'd5, 32'h1, 32'h2, 32'h3, 5, ok);
        send(32'h8000_0002, 32'h1, 32'h2, 32'h3, 5, ok);
        tick(); tick();
        chk("t3_red_pulses", 64'(red_cnt - r0), 3);
        chk("t3_doluluk", doluluk_c, 0);
        send(32'd4, 32'h11, 32'h22, 32'h33, 5, ok);
        drain(100);

        // multiplier never starts: timeout freezes the queue
        do_reset();
        mul_respond = 1'b0;
        g0 = gec_cnt;
        send(32'd1, 32'h10, 32'h20, 32'h30, 5, ok);
        wait_issue(g0);
        for (int w = 0; w < 40 && cyc < last_gec_cyc + SURE; w++) tick();
        @(negedge clk_g);
        chk("t5_no_timeout_yet", zaman_asimi_c, 0);
        tick();
        exp_stuck = 1'b1;
        chk("t5_zaman_asimi_c", zaman_asimi_c, 1);
        chk("t5_is_hazir_c", bus.is_hazir_c, 0);
        b0 = bitti_cnt;
        repeat (20) tick();
        chk("t5_no_bitti", 64'(bitti_cnt), 64'(b0));
        send(32'd2, 32'h1, 32'h2, 32'h3, 0, ok);
        chk("t5_still_stuck", zaman_asimi_c, 1);
        do_reset();
        mul_respond = 1'b1;

        // reset mid-job drops queue; ID restarts at 0
        mul_len = 300;
        for (int i = 0; i < 3; i++) send(32'd3, $urandom, $urandom, $urandom, 5, ok);
        for (int w = 0; w < 20 && !bus.at_mesgul_g; w++) tick();
        tick(); tick();
        chk("t6_doluluk_before", doluluk_c, 3);
        mul_abort = 1'b1;
        b0 = bitti_cnt;
        do_reset();
        tick(); tick();
        mul_abort = 1'b0;
        mul_len = 0;
        chk("t6_no_bitti", 64'(bitti_cnt), 64'(b0));
        send(32'd2, 32'h4, 32'h5, 32'h6, 5, ok);
        drain(100);

        // randomized traffic with random multiplier timing
        for (int n = 0; n < 40; n++) begin
            rb = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 6));
            repeat ($urandom_range(0, 3)) tick();
            send(rb, $urandom, $urandom, $urandom, 300, ok);
            if (!ok) fail_now("rand_accept", "job never accepted within cycle budget");
        end
        drain(3000);
        tick(); tick();
        chk("red_all_seen", red_cyc_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
